// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial pattern detectors: KMP transition/failure functions
// evaluated at elaboration, plus the prefix_len width helper.
package seq_det_pkg;

  localparam int MAX_PAT = 16;

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic pat_bit(logic [MAX_PAT-1:0] pattern, int len, int i);
    return pattern[len-1-i];
  endfunction

  // Longest L <= k+1 such that the last L-1 accepted bits equal prefix(L-1) and bit L-1 == b.
  function automatic int kmp_next(logic [MAX_PAT-1:0] pattern, int len, int k, logic b);
    int   res;
    logic ok;
    res = 0;
    for (int l = MAX_PAT; l >= 1; l--) begin
      if (res == 0 && l <= k + 1 && l <= len) begin
        ok = (pat_bit(pattern, len, l - 1) == b);
        for (int j = 0; j < MAX_PAT - 1; j++)
          if (j < l - 1 && pat_bit(pattern, len, j) != pat_bit(pattern, len, k - (l - 1) + j))
            ok = 1'b0;
        if (ok) res = l;
      end
    end
    return res;
  endfunction

  // Longest proper prefix of the pattern that is also a suffix.
  function automatic int kmp_fail(logic [MAX_PAT-1:0] pattern, int len);
    int   res;
    logic ok;
    res = 0;
    for (int l = MAX_PAT - 1; l >= 1; l--) begin
      if (res == 0 && l < len) begin
        ok = 1'b1;
        for (int j = 0; j < MAX_PAT - 1; j++)
          if (j < l && pat_bit(pattern, len, j) != pat_bit(pattern, len, len - l + j))
            ok = 1'b0;
        if (ok) res = l;
      end
    end
    return res;
  endfunction

  function automatic int pl_w(int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with sticky saturation flag and synchronous clear.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX  = '1;
  localparam logic [CNT_W-1:0] NEAR = MAX - CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && count != MAX) begin
      count <= count + CNT_W'(1);
      if (count == NEAR) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: KMP automaton with a table built at elaboration,
// registered one-cycle match pulse and saturating match counter.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int                  PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]  PATTERN = 4'b1101,
  parameter int                  OVERLAP = 1,
  parameter int                  CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_valid,
  input  logic                        in_bit,
  output logic                        match,
  output logic [pl_w(PAT_LEN)-1:0]    prefix_len,
  output logic [CNT_W-1:0]            match_count,
  output logic                        count_sat
);

  localparam int                PW   = pl_w(PAT_LEN);
  localparam logic [MAX_PAT-1:0] PATX = MAX_PAT'(PATTERN);
  localparam logic [PW-1:0]     FAIL = PW'(kmp_fail(PATX, PAT_LEN));
  localparam logic [PW-1:0]     DONE = PW'(PAT_LEN);

  // One entry per state plus an unused top entry so prefix_len indexes the table at full width.
  logic [PAT_LEN:0][PW-1:0] tbl0, tbl1;
  logic [PW-1:0]            knext;
  logic                     hit;

  for (genvar k = 0; k < PAT_LEN; k++) begin : g_tbl
    localparam int N0 = kmp_next(PATX, PAT_LEN, k, 1'b0);
    localparam int N1 = kmp_next(PATX, PAT_LEN, k, 1'b1);
    assign tbl0[k] = PW'(N0);
    assign tbl1[k] = PW'(N1);
  end
  assign tbl0[PAT_LEN] = '0;
  assign tbl1[PAT_LEN] = '0;

  assign knext = in_bit ? tbl1[prefix_len] : tbl0[prefix_len];
  assign hit   = in_valid && !clr && (knext == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prefix_len <= '0;
      match      <= 1'b0;
    end else if (clr) begin
      prefix_len <= '0;
      match      <= 1'b0;
    end else if (in_valid) begin
      match      <= hit;
      prefix_len <= hit ? ((OVERLAP != 0) ? FAIL : '0) : knext;
    end else begin
      match <= 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (hit),
    .count (match_count),
    .sat   (count_sat)
  );

endmodule
